// File: rtl/scic_pkg.sv
// rtl/scic_pkg.sv - shared SCIC CPU widths, fetch state enum and buffer entry type
// Contents:
//   ADDR_WIDTH     ROM word-address width (used by ROM, PC, decode)
//   DATA_WIDTH     instruction word width
//   fetch_state_e  fetch FSM states
//   fetch_entry_t  prefetch buffer entry {pc, data}
package scic_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - ROM bus, instruction handshake and redirect signals of the fetch unit
// Signals:
//   rom_address, rom_chip_select   fetch -> ROM
//   rom_data                       ROM -> fetch (high-Z when deselected)
//   instr_valid, instr_data,
//   instr_pc                       fetch -> decode
//   instr_ready                    decode -> fetch
//   redirect, redirect_address     execute -> fetch
// Modports: master = fetch unit, slave = its environment (ROM + decode/execute).
interface instr_fetch_if;

  logic [scic_pkg::ADDR_WIDTH-1:0] rom_address;
  logic                            rom_chip_select;
  logic [scic_pkg::DATA_WIDTH-1:0] rom_data;
  logic                            instr_valid;
  logic                            instr_ready;
  logic [scic_pkg::DATA_WIDTH-1:0] instr_data;
  logic [scic_pkg::ADDR_WIDTH-1:0] instr_pc;
  logic                            redirect;
  logic [scic_pkg::ADDR_WIDTH-1:0] redirect_address;

  modport master (
    output rom_address,
    output rom_chip_select,
    input  rom_data,
    output instr_valid,
    input  instr_ready,
    output instr_data,
    output instr_pc,
    input  redirect,
    input  redirect_address
  );

  modport slave (
    input  rom_address,
    input  rom_chip_select,
    output rom_data,
    input  instr_valid,
    output instr_ready,
    input  instr_data,
    input  instr_pc,
    output redirect,
    output redirect_address
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - DEPTH-entry synchronous prefetch FIFO of {pc, data}
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   push        write wr_entry at the tail (ignored when full)
//   pop         remove the head (ignored when empty)
//   flush       empty the FIFO; overrides push and pop
//   wr_entry    entry to write
//   head        current head entry (stale contents while empty)
//   count       number of stored entries, 0..DEPTH
module fetch_fifo
  import scic_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  fetch_entry_t   wr_entry,
  output fetch_entry_t   head,
  output logic [CW-1:0]  count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            push_ok;
  logic            pop_ok;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  assign push_ok = push && (count < CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is read straight from storage so the reset value of the outputs is zero.
  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch initiator: ROM addressing, prefetch buffer, redirect
// Ports:
//   clk     clock, all state on the rising edge
//   reset   asynchronous active-high reset
//   enable  fetching permitted while high
//   bus     instr_fetch_if.master: ROM address/chip-select/data,
//           instr valid/ready/data/pc handshake, redirect/redirect_address
module instr_fetch
  import scic_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  instr_fetch_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e           state_q;
  fetch_state_e           state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q;
  logic [CW-1:0]          count;
  logic                   chip_select;
  logic                   push;
  logic                   pop;
  fetch_entry_t           wr_entry;
  fetch_entry_t           head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Chip-select depends only on registered state and count, so the ROM
  // never sees a combinational path from enable, ready or redirect.
  always_comb begin
    state_d     = state_q;
    chip_select = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        chip_select = (count < CW'(DEPTH));
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A redirect discards the word on the bus this cycle; the flush inside
  // the FIFO also outranks the pop, which still counts as a transfer.
  assign push = chip_select && !bus.redirect;
  assign pop  = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_ADDR;
    end else if (bus.redirect) begin
      fetch_pc_q <= bus.redirect_address;
    end else if (push) begin
      fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(1);
    end
  end

  assign wr_entry.pc   = fetch_pc_q;
  assign wr_entry.data = bus.rom_data;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (bus.redirect),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  assign bus.rom_address     = fetch_pc_q;
  assign bus.rom_chip_select = chip_select;
  assign bus.instr_valid     = (count != '0);
  assign bus.instr_data      = head.data;
  assign bus.instr_pc        = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic clk;
  logic reset;
  logic enable;
  logic [31:0] mem [32];
  int total;
  int bad;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_ADDR (5'd0),
    .DEPTH      (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  // Combinational ROM, floating when deselected.
  assign bus.rom_data = bus.rom_chip_select ? mem[bus.rom_address] : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(bus.rom_address), 32'd0);
    check({tag, "_cs"},    32'(bus.rom_chip_select), 32'd0);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_data"},  bus.instr_data, 32'd0);
    check({tag, "_pc"},    32'(bus.instr_pc), 32'd0);
  endtask

  task automatic check_head(input string tag, input int pc);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_pc"},    32'(bus.instr_pc), 32'(pc));
    check({tag, "_data"},  bus.instr_data, 32'(pc) * 32'h01010101);
  endtask

  initial begin
    int exp_pc [4];
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i) * 32'h01010101;
    reset                = 1'b1;
    enable               = 1'b0;
    bus.instr_ready      = 1'b0;
    bus.redirect         = 1'b0;
    bus.redirect_address = '0;

    // Reset state and start-up stream.
    @(negedge clk);
    check_reset_outputs("reset");
    reset           = 1'b0;
    enable          = 1'b1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("start_cs",    32'(bus.rom_chip_select), 32'd1);
    check("start_valid", 32'(bus.instr_valid), 32'd0);
    check("start_addr",  32'(bus.rom_address), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_head("stream", i);
    end

    // Back-pressure from a fresh start.
    reset           = 1'b1;
    enable          = 1'b0;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check("bp_cs0",    32'(bus.rom_chip_select), 32'd1);
    check("bp_valid0", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    check("bp_pc1",   32'(bus.instr_pc), 32'd0);
    check("bp_cs1",   32'(bus.rom_chip_select), 32'd1);
    check("bp_addr1", 32'(bus.rom_address), 32'd1);
    @(negedge clk);
    check("bp_cs2",   32'(bus.rom_chip_select), 32'd0);
    check("bp_addr2", 32'(bus.rom_address), 32'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_head("drain", i);
      if (i == 0) begin
        check("bp_cs3",   32'(bus.rom_chip_select), 32'd0);
        check("bp_addr3", 32'(bus.rom_address), 32'd2);
        bus.instr_ready = 1'b1;
      end
    end

    // Redirect to 30 with ready high; wrap past 31.
    bus.redirect         = 1'b1;
    bus.redirect_address = 5'd30;
    @(negedge clk);
    check("rd_bubble", 32'(bus.instr_valid), 32'd0);
    check("rd_addr",   32'(bus.rom_address), 32'd30);
    check("rd_cs",     32'(bus.rom_chip_select), 32'd1);
    bus.redirect = 1'b0;
    exp_pc = '{30, 31, 0, 1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_head("wrap", exp_pc[i]);
    end

    // Fill with pcs 4,5 under back-pressure, then redirect to 12.
    bus.instr_ready      = 1'b0;
    bus.redirect         = 1'b1;
    bus.redirect_address = 5'd4;
    @(negedge clk);
    bus.redirect = 1'b0;
    check("fill_valid0", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    check_head("fill_head4", 4);
    @(negedge clk);
    check_head("full_head4", 4);
    check("full_cs",   32'(bus.rom_chip_select), 32'd0);
    check("full_addr", 32'(bus.rom_address), 32'd6);
    bus.redirect         = 1'b1;
    bus.redirect_address = 5'd12;
    @(negedge clk);
    check("flush_valid", 32'(bus.instr_valid), 32'd0);
    check("flush_addr",  32'(bus.rom_address), 32'd12);
    check("flush_cs",    32'(bus.rom_chip_select), 32'd1);
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check_head("after_flush", 12);

    // Asynchronous reset between edges.
    @(negedge clk);
    check_head("pre_reset", 13);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("restart_cs",    32'(bus.rom_chip_select), 32'd1);
    check("restart_addr",  32'(bus.rom_address), 32'd0);
    check("restart_valid", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_head("restart", i);
    end

    // Drop enable with one entry left and fetch_pc landing on 7.
    enable = 1'b0;
    @(negedge clk);
    check("dis_cs",   32'(bus.rom_chip_select), 32'd0);
    check("dis_addr", 32'(bus.rom_address), 32'd7);
    check_head("dis_head", 6);
    bus.instr_ready = 1'b0;
    @(negedge clk);
    check_head("dis_hold", 6);
    check("dis_cs2", 32'(bus.rom_chip_select), 32'd0);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("dis_empty", 32'(bus.instr_valid), 32'd0);
    check("dis_cs3",   32'(bus.rom_chip_select), 32'd0);
    check("dis_addr3", 32'(bus.rom_address), 32'd7);
    enable = 1'b1;
    @(negedge clk);
    check("reen_cs",    32'(bus.rom_chip_select), 32'd1);
    check("reen_addr",  32'(bus.rom_address), 32'd7);
    check("reen_valid", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    check_head("reen", 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch initiator for the SCIC CPU. It drives the combinational instruction ROM's address and chip-select lines and captures each returned 32-bit word. Captured words go into a small prefetch buffer, which hands instructions and their addresses to the decode/execute stage over a valid/ready handshake. It also supports a single-cycle redirect for jumps and branches.

## Interface
- ADDR_WIDTH, 5, ROM word-address width (32 words).
- DATA_WIDTH, 32, instruction width.
- RESET_ADDR, 0, fetch address loaded on reset.
- DEPTH, 2, prefetch buffer entries; power of two, at least 2.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  fetch permitted while high.
- rom_address  output  ADDR_WIDTH  ROM word address; always equals the fetch PC register.
- rom_chip_select  output  1  ROM enable; high only in cycles whose ROM data will be captured.
- rom_data  input  DATA_WIDTH  ROM read data; combinational from rom_address and chip-select; tri-stated when deselected.
- instr_valid  output  1  buffer head holds an instruction.
- instr_ready  input  1  consumer accepts the head this cycle.
- instr_data  output  DATA_WIDTH  head instruction word.
- instr_pc  output  ADDR_WIDTH  address the head word was fetched from.
- redirect  input  1  flush the buffer and restart fetch at redirect_address.
- redirect_address  input  ADDR_WIDTH  new fetch address.

## Operation
- States:
  - IDLE: reset state.
  - RUN.
- Transitions, sampled at the clock edge:
  - IDLE to RUN when enable is 1.
  - RUN to IDLE when enable is 0.
  - redirect does not change state.
- rom_chip_select = (state == RUN) and (count < DEPTH). It is a function of registered state only, with no combinational path from any input.
- Fetch edge: any edge where rom_chip_select is 1 and redirect is 0.
  - {rom_data, fetch_pc} is pushed into the buffer.
  - fetch_pc becomes fetch_pc + 1, modulo 2^ADDR_WIDTH, so 31 wraps to 0.
- rom_data is never sampled while rom_chip_select is 0, because the bus is high-Z then.
- Pop: when instr_valid and instr_ready are both 1, the head is removed.
  - A pop and a push on the same edge are both honoured; count is unchanged.
  - A push is gated by the count registered before the edge, so a full buffer with a pop does not push that edge.
- Redirect edge, which has priority over push and pop:
  - count becomes 0 and the ROM word present that cycle is discarded.
  - fetch_pc becomes redirect_address.
  - A head presented with instr_ready high in the redirect cycle counts as transferred.
  - Redirect is honoured in IDLE as well; it sets fetch_pc with no fetch.
- enable low stops new fetches only. Buffered entries stay valid and drain normally, and fetch_pc is preserved.
- instr_valid = (count != 0). instr_data and instr_pc come directly from the head registers.

## Timing
- Reset values:
  - state IDLE, fetch_pc RESET_ADDR, count 0.
  - rom_address RESET_ADDR, rom_chip_select 0.
  - instr_valid 0, instr_data 0, instr_pc 0.
- Start-up latency: enable seen high at edge E0 gives rom_chip_select high in cycle E0..E1, a capture at E1, and instr_valid high in cycle E1..E2.
- Throughput: one instruction per cycle while instr_ready stays high.
- Back-pressure: with instr_ready low, at most DEPTH captures occur. rom_chip_select falls the cycle after count reaches DEPTH, and rom_address holds the next unfetched address.
- Redirect: redirect at edge R gives instr_valid 0 in cycle R..R+1, rom_address = redirect_address with chip-select high in that cycle, and the new instruction valid in cycle R+1..R+2. This is a one-cycle bubble.
- Reset asserted mid-operation forces every output to its reset value asynchronously, without waiting for a clock. Release is synchronous to the next edge.

## Structure
- scic_pkg holds the shared definitions:
  - ADDR_WIDTH and DATA_WIDTH constants, also used by ROM, PC and decode.
  - the fetch state enum (IDLE, RUN).
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of {pc, data}.
  - Inputs: push, pop, flush.
  - Outputs: head, count.
  - Flush has priority over push and pop.
- instr_fetch itself holds the state register, fetch_pc and the chip-select logic.

## Test plan
- ROM preloaded with mem[i] = i * 0x01010101, reset, then enable high with instr_ready high → instr_valid first high 2 edges after enable. instr_pc reads 0,1,2,3… and instr_data reads 0x00000000, 0x01010101, 0x02020202…, one per cycle.
- instr_ready held low after start-up → exactly 2 captures, rom_chip_select low from the next cycle, rom_address = 2. Release instr_ready → pcs 0..5 delivered in order with no duplicates or gaps.
- redirect to address 30 with instr_ready high → next delivered pcs are 30, 31, 0, 1. Wrap carries no error, and instr_valid shows a single bubble cycle.
- Buffer full (pcs 4,5) with instr_ready low, then redirect to 12 → instr_valid 0 the next cycle and next delivered pc is 12. Entries 4 and 5 are never presented.
- Reset pulsed between clock edges mid-run → all outputs at reset values before the next edge. After release plus enable, fetch restarts at RESET_ADDR.
- enable dropped while 1 entry is buffered at fetch_pc 7 → rom_chip_select low the next cycle and the entry still drains. Re-enable → fetch resumes at 7.
